// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard-model transmitter.
//   - APB register offsets (paddr[3:2])
//   - STATUS / CTRL bit positions
//   - frame length and the frame FSM state type
//   - build_frame(): assembles an 11-bit device-to-host frame, bit 0 first
package ps2_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int STATUS_EMPTY_BIT = 4;
    localparam int STATUS_FULL_BIT  = 5;
    localparam int STATUS_BUSY_BIT  = 6;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_BADPAR_BIT  = 1;

    localparam int FRAME_BITS = 11;

    // state     | meaning
    // S_IDLE    | lines high, waiting for enable and a queued byte
    // S_HIGH    | ps2_clk high, current bit presented on ps2_data
    // S_LOW     | ps2_clk low, host samples the bit on the falling edge
    // S_GAP     | both lines high between frames
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_GAP  = 2'd3
    } tx_state_t;

    // Index i of the result is the i-th bit on the wire:
    // start 0, d0..d7, odd parity (optionally inverted), stop 1.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data,
                                                          input logic       bad_parity);
        return {1'b1, (~^data) ^ bad_parity, data, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// ps2_tx_fifo: synchronous byte FIFO feeding the PS/2 frame FSM.
// Ports:
//   clock, reset      system clock, sync active-high reset (empties the FIFO)
//   push, din         write a byte (ignored when full)
//   pop, dout         consume the head byte; dout shows the head while not empty
//   count, full, empty occupancy flags, count is $clog2(DEPTH)+1 bits wide
module ps2_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_tx_apb.sv
// ps2_kbd_tx_apb: PS/2 keyboard model. Bytes written over APB are queued and
// sent as 11-bit device-to-host frames on ps2_clk/ps2_data.
// Ports:
//   clock, reset              system clock, sync active-high reset
//   in_p*                     APB slave, one wait state, regs at paddr[3:2]:
//                             0 DATA (W), 1 STATUS (RO), 2 CTRL (R/W), 3 error
//   ps2_clk, ps2_data         registered PS/2 lines, idle high
module ps2_kbd_tx_apb #(
    parameter int CLK_HALF   = 50,
    parameter int GAP        = 100,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_paddr,
    input  logic        in_psel,
    input  logic        in_penable,
    input  logic [2:0]  in_pprot,
    input  logic        in_pwrite,
    input  logic [31:0] in_pwdata,
    input  logic [3:0]  in_pstrb,
    output logic        in_pready,
    output logic [31:0] in_prdata,
    output logic        in_pslverr,
    output logic        ps2_clk,
    output logic        ps2_data
);
    import ps2_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_HALF - 1);
    // The IDLE cycle that pops the next byte is the last cycle of the gap,
    // so the GAP state itself runs GAP-1 cycles.
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP - 2);
    localparam logic [3:0]       LAST_BIT  = 4'(FRAME_BITS - 1);

    logic            fifo_push;
    logic            fifo_pop;
    logic [7:0]      fifo_dout;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;

    logic            ctrl_en;
    logic            ctrl_bad;

    tx_state_t       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [3:0]      idx, idx_nx;
    logic [FRAME_BITS-1:0] frame, frame_nx;
    logic            clk_nx, data_nx;
    logic            busy;

    ps2_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .din   (in_pwdata[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ---------------- APB ----------------
    logic        access;
    logic        xfer;
    logic [1:0]  reg_sel;
    logic        data_wr;
    logic [31:0] status_word;
    logic [31:0] rdata_d;
    logic        err_d;
    logic        unused_inputs;

    assign access  = in_psel & in_penable;
    // First access cycle; the register effect lands on the edge that raises pready.
    assign xfer    = access & ~in_pready;
    assign reg_sel = in_paddr[3:2];
    assign data_wr = xfer & in_pwrite & (reg_sel == REG_DATA) & in_pstrb[0];
    // Full is judged before any same-cycle pop, so an overflow always drops.
    assign fifo_push = data_wr & ~fifo_full;
    assign busy    = (state != S_IDLE);

    assign unused_inputs = ^{in_pprot, in_paddr[31:4], in_paddr[1:0],
                             in_pstrb[3:1], in_pwdata[31:8]};

    always_comb begin
        status_word = '0;
        status_word[3:0]              = 4'(fifo_count);
        status_word[STATUS_EMPTY_BIT] = fifo_empty;
        status_word[STATUS_FULL_BIT]  = fifo_full;
        status_word[STATUS_BUSY_BIT]  = busy;
    end

    always_comb begin
        rdata_d = '0;
        err_d   = 1'b0;
        case (reg_sel)
            REG_DATA:   err_d = in_pwrite & in_pstrb[0] & fifo_full;
            REG_STATUS: if (!in_pwrite) rdata_d = status_word;
            REG_CTRL:   if (!in_pwrite) rdata_d = {30'b0, ctrl_bad, ctrl_en};
            default:    err_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            in_pready  <= 1'b0;
            in_prdata  <= '0;
            in_pslverr <= 1'b0;
            ctrl_en    <= 1'b1;
            ctrl_bad   <= 1'b0;
        end else begin
            in_pready  <= xfer;
            in_prdata  <= xfer ? rdata_d : '0;
            in_pslverr <= xfer & err_d;
            if (xfer && in_pwrite && reg_sel == REG_CTRL) begin
                ctrl_en  <= in_pwdata[CTRL_EN_BIT];
                ctrl_bad <= in_pwdata[CTRL_BADPAR_BIT];
            end
        end
    end

    // ---------------- frame FSM ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            frame    <= '1;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            idx      <= idx_nx;
            frame    <= frame_nx;
            ps2_clk  <= clk_nx;
            ps2_data <= data_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        frame_nx = frame;
        fifo_pop = 1'b0;
        case (state)
            S_IDLE: begin
                if (ctrl_en && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    frame_nx = build_frame(fifo_dout, ctrl_bad);
                    idx_nx   = '0;
                    cnt_nx   = HALF_LOAD;
                    state_nx = S_HIGH;
                end
            end
            S_HIGH: begin
                if (cnt == '0) begin
                    cnt_nx   = HALF_LOAD;
                    state_nx = S_LOW;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            S_LOW: begin
                if (cnt == '0) begin
                    if (idx == LAST_BIT) begin
                        cnt_nx   = GAP_LOAD;
                        state_nx = S_GAP;
                    end else begin
                        idx_nx   = idx + 1'b1;
                        cnt_nx   = HALF_LOAD;
                        state_nx = S_HIGH;
                    end
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            S_GAP: begin
                if (cnt == '0) begin
                    state_nx = S_IDLE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so the registered lines line
    // up with the state register.
    always_comb begin
        clk_nx  = 1'b1;
        data_nx = 1'b1;
        case (state_nx)
            S_HIGH: data_nx = frame_nx[idx_nx];
            S_LOW: begin
                clk_nx  = 1'b0;
                data_nx = frame_nx[idx_nx];
            end
            default: ;
        endcase
    end

endmodule
